md_rx_responder: RTL and testbench
==================================

// Module: md_rx_responder
// PURPOSE
//  Responder end of the MD valid/ready protocol: accepts MD transfers (data/offset/size),
//  answers with ready and err, and unpacks the size valid bytes starting at byte offset
//  into an internal byte FIFO drained by a byte stream (out_valid/out_data/out_ready).
//  Sits at the RX side of the aligner datapath, in front of the byte-alignment logic.
// PARAMETERS
//  DATA_WIDTH   32  MD data width in bits; power of 2, >= 8
//  FIFO_DEPTH   16  byte FIFO depth; power of 2, >= DATA_WIDTH/8
//  READY_DELAY  0   wait states inserted before ready for a legal transfer (0..15)
// PORTS
//  clk        in   1                    clock, all logic on posedge
//  reset      in   1                    synchronous, active-high
//  md_valid   in   1                    MD transfer valid
//  md_data    in   DATA_WIDTH           MD data
//  md_offset  in   max(1,log2(DW/8))    first valid byte lane
//  md_size    in   log2(DW/8)+1         number of valid bytes
//  md_ready   out  1                    transfer accepted (registered)
//  md_err     out  1                    transfer rejected (registered, only with md_ready)
//  out_valid  out  1                    FIFO not empty
//  out_data   out  8                    byte at FIFO head
//  out_ready  in   1                    downstream pop
//  fill_level out  log2(FIFO_DEPTH)+1   bytes currently held
// BEHAVIOUR
//  Reset: md_ready=0, md_err=0, out_valid=0, out_data=0, fill_level=0, pointers=0,
//   FSM=IDLE; FIFO content and any in-progress transfer discarded. Reset wins over all.
//  Legality: illegal iff md_size==0 or md_size+md_offset > DATA_WIDTH/8 (sum computed
//   one bit wider than md_size, no wrap).
//  FSM IDLE -> WAIT -> RESP -> IDLE:
//   IDLE: md_valid=1 at edge: illegal -> RESP with err pending; legal -> WAIT, wait_cnt=0.
//   WAIT: at each edge where wait_cnt>=READY_DELAY and free space (FIFO_DEPTH-fill_level)
//    >= md_size -> RESP; else wait_cnt++ (saturating). Space stall is unbounded.
//   RESP: md_ready=1 for exactly one cycle; md_err=1 during it iff illegal. At the edge
//    ending RESP the transfer completes: legal -> push bytes md_data[8*(offset+i)+:8],
//    i=0..size-1, in ascending order; illegal -> nothing pushed. Next state IDLE.
//  Latency (READY_DELAY=0, space ok): md_valid seen at edge E0 -> WAIT; E1 -> RESP
//   (md_ready high in cycle E1..E2); complete at E2. Illegal: md_ready high after E0.
//   md_ready is low for >=1 cycle between transfers; peak rate 1 transfer / 3 cycles.
//  md_valid drop in WAIT (protocol violation): return to IDLE, nothing pushed, no ready.
//  FIFO: circular, pointers wrap mod FIFO_DEPTH; push of N bytes wraps across end.
//   Pop when out_valid & out_ready: 1 byte/cycle. out_valid = (fill_level!=0);
//   out_data = head byte, 0 when empty.
//  Simultaneous push and pop same edge: fill_level += size-1; space check for
//   RESP uses fill_level before the pop (conservative). Never overflows or underflows.
//  Full: legal transfer stalls in WAIT with md_ready=0 until space frees.
//  md_err never high without md_ready; md_ready/md_err never X after reset.
// TESTING (DATA_WIDTH=32, FIFO_DEPTH=16, READY_DELAY=0 unless stated)
//  1. data=32'hDDCCBBAA, offset=1, size=2 -> ready after 2 edges, err=0; pops 8'hBB, 8'hCC.
//  2. size=0, then offset=3,size=2 -> each answered with ready=1,err=1 next cycle; fill_level=0.
//  3. out_ready=0, four size=4 transfers fill 16; fifth stalls with ready=0; one pop
//     still stalls (15 left, need 4); 4 pops -> ready rises, fill_level ends at 16.
//  4. READY_DELAY=3, legal size=1 -> ready high exactly 4 edges after valid seen, 1 cycle.
//  5. Wrap: 14 bytes pushed and popped, then size=4 data=32'h44332211 -> bytes straddle
//     index 15/0, popped in order 11,22,33,44.
//  6. reset asserted while in WAIT with fill_level=5 -> next cycle ready=0, err=0,
//     fill_level=0, out_valid=0; a new transfer then completes normally.

Source files
------------

// File: rtl/md_rx_responder.sv
// Responder end of the MD valid/ready protocol: answers each transfer with ready/err and
// unpacks its valid byte lanes into a circular byte FIFO drained by a byte stream.
module md_rx_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int READY_DELAY = 0,
    localparam int NB     = DATA_WIDTH / 8,
    localparam int OFF_W  = (NB > 1) ? $clog2(NB) : 1,
    localparam int SIZE_W = $clog2(NB) + 1,
    localparam int PTR_W  = $clog2(FIFO_DEPTH),
    localparam int LVL_W  = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  md_valid,
    input  logic [DATA_WIDTH-1:0] md_data,
    input  logic [OFF_W-1:0]      md_offset,
    input  logic [SIZE_W-1:0]     md_size,
    output logic                  md_ready,
    output logic                  md_err,
    output logic                  out_valid,
    output logic [7:0]            out_data,
    input  logic                  out_ready,
    output logic [LVL_W-1:0]      fill_level
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic                  err_pend_r;
    logic                  err_next_s;
    logic [3:0]            wait_cnt_r;
    logic [3:0]            wait_cnt_next_s;
    logic                  md_ready_r;
    logic                  md_err_r;

    logic [7:0]            mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [LVL_W-1:0]      fill_r;

    logic [SIZE_W:0]       span_s;
    logic                  illegal_s;
    logic [LVL_W-1:0]      free_s;
    logic                  space_ok_s;
    logic                  push_s;
    logic                  pop_s;
    logic [LVL_W-1:0]      push_cnt_s;
    logic [DATA_WIDTH-1:0] lanes_s;

    // Span is one bit wider than md_size so offset+size never wraps into a legal value
    assign span_s     = {1'b0, md_size} + (SIZE_W + 1)'(md_offset);
    assign illegal_s  = (md_size == {SIZE_W{1'b0}}) || (span_s > (SIZE_W + 1)'(NB));
    // Space test ignores a same-edge pop, so a push can never overflow
    assign free_s     = LVL_W'(FIFO_DEPTH) - fill_r;
    assign space_ok_s = (free_s >= LVL_W'(md_size));
    assign push_s     = (state_r == ST_RESP) && !err_pend_r;
    assign pop_s      = (fill_r != {LVL_W{1'b0}}) && out_ready;
    assign push_cnt_s = push_s ? LVL_W'(md_size) : {LVL_W{1'b0}};
    assign lanes_s    = md_data >> {md_offset, 3'b000};

    // Next-state and wait-counter decode for the response handshake
    always_comb begin
        state_next_s    = state_r;
        err_next_s      = err_pend_r;
        wait_cnt_next_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (md_valid) begin
                    if (illegal_s) begin
                        state_next_s = ST_RESP;
                        err_next_s   = 1'b1;
                    end else begin
                        state_next_s    = ST_WAIT;
                        err_next_s      = 1'b0;
                        wait_cnt_next_s = 4'd0;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!md_valid) begin
                    state_next_s = ST_IDLE;
                end else if ((wait_cnt_r >= 4'(READY_DELAY)) && space_ok_s) begin
                    state_next_s = ST_RESP;
                end else if (wait_cnt_r != 4'hF) begin
                    wait_cnt_next_s = wait_cnt_r + 4'd1;
                end else begin
                    wait_cnt_next_s = wait_cnt_r;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                err_next_s   = 1'b0;
            end
        endcase
    end

    // FSM state plus registered ready/err, both decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            err_pend_r <= 1'b0;
            wait_cnt_r <= 4'd0;
            md_ready_r <= 1'b0;
            md_err_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            err_pend_r <= err_next_s;
            wait_cnt_r <= wait_cnt_next_s;
            md_ready_r <= (state_next_s == ST_RESP);
            md_err_r   <= (state_next_s == ST_RESP) && err_next_s;
        end
    end

    // FIFO pointers and fill level; push and pop may share an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            fill_r   <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + push_cnt_s[PTR_W-1:0];
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
            fill_r   <= fill_r + push_cnt_s - LVL_W'(pop_s);
        end
    end

    // Byte storage: lane i of the shifted word lands at wr_ptr+i, wrapping at the end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_r[j] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (push_s && (SIZE_W'(i) < md_size)) begin
                    mem_r[wr_ptr_r + PTR_W'(i)] <= lanes_s[8*i +: 8];
                end
            end
        end
    end

    assign md_ready   = md_ready_r;
    assign md_err     = md_err_r;
    assign fill_level = fill_r;
    assign out_valid  = (fill_r != {LVL_W{1'b0}});
    assign out_data   = (fill_r != {LVL_W{1'b0}}) ? mem_r[rd_ptr_r] : 8'h00;

endmodule

// File: tb/tb_md_rx_responder.sv
// Bench for md_rx_responder: directed and random MD transfers checked against a byte-queue
// model; a second instance with READY_DELAY=3 checks the wait-state timing.
module tb_md_rx_responder;

    logic        clk;
    logic        reset;
    logic        md_valid;
    logic [31:0] md_data;
    logic [1:0]  md_offset;
    logic [2:0]  md_size;
    logic        md_ready;
    logic        md_err;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic [4:0]  fill_level;

    logic        d_valid;
    logic [31:0] d_data;
    logic [1:0]  d_offset;
    logic [2:0]  d_size;
    logic        d_ready;
    logic        d_err;
    logic        d_out_valid;
    logic [7:0]  d_out_data;
    logic        d_out_ready;
    logic [4:0]  d_fill;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [7:0]  model_q[$];
    bit          push_pend = 0;
    logic [31:0] push_d;
    int          push_off;
    int          push_sz;
    int          pop_budget = 0;

    md_rx_responder #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .READY_DELAY(0)) dut (
        .clk(clk), .reset(reset), .md_valid(md_valid), .md_data(md_data),
        .md_offset(md_offset), .md_size(md_size), .md_ready(md_ready), .md_err(md_err),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .fill_level(fill_level)
    );

    md_rx_responder #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .READY_DELAY(3)) dut_d3 (
        .clk(clk), .reset(reset), .md_valid(d_valid), .md_data(d_data),
        .md_offset(d_offset), .md_size(d_size), .md_ready(d_ready), .md_err(d_err),
        .out_valid(d_out_valid), .out_data(d_out_data), .out_ready(d_out_ready),
        .fill_level(d_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive out_ready, apply pop/push to the model, then check the FIFO view
    task automatic step();
        bit          pop_now;
        logic [31:0] tmp;
        logic [7:0]  head;
        out_ready = (pop_budget < 0) ? 1'($urandom_range(0, 1)) : (pop_budget > 0);
        pop_now   = (model_q.size() != 0) && out_ready;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            push_pend = 0;
        end else begin
            if (pop_now) begin
                void'(model_q.pop_front());
                if (pop_budget > 0) pop_budget--;
            end
            if (push_pend) begin
                for (int i = 0; i < push_sz; i++) begin
                    tmp = push_d >> (8 * (push_off + i));
                    model_q.push_back(tmp[7:0]);
                end
                push_pend = 0;
            end
        end
        #1;
        head = (model_q.size() != 0) ? model_q[0] : 8'h00;
        chk("fill_level", 32'(fill_level), 32'(model_q.size()));
        chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        chk("out_data", 32'(out_data), 32'(head));
    endtask

    // Present a transfer and take the first edge; illegal ones are answered and retired here
    task automatic begin_xfer(input logic [31:0] d, input int off, input int sz, output bit legal);
        legal     = (sz != 0) && (sz + off <= 4);
        md_data   = d;
        md_offset = 2'(off);
        md_size   = 3'(sz);
        md_valid  = 1'b1;
        step();
        if (!legal) begin
            chk("ill_ready", 32'(md_ready), 32'd1);
            chk("ill_err", 32'(md_err), 32'd1);
            md_valid = 1'b0;
            step();
            chk("ill_ready_drop", 32'(md_ready), 32'd0);
            chk("ill_err_drop", 32'(md_err), 32'd0);
        end else begin
            chk("wait_ready_low", 32'(md_ready), 32'd0);
        end
    endtask

    // Ready is expected at the first edge where the pre-pop free space covers the size
    task automatic wait_ready(input int sz, input int max_cyc, output bit got, output int cyc);
        bit exp;
        got = 0;
        cyc = 0;
        while (!got && cyc < max_cyc) begin
            exp = (16 - model_q.size()) >= sz;
            step();
            cyc++;
            chk("ready_vs_space", 32'(md_ready), 32'(exp));
            chk("err_legal", 32'(md_err), 32'd0);
            got = exp;
        end
    endtask

    task automatic finish_xfer(input logic [31:0] d, input int off, input int sz);
        md_valid  = 1'b0;
        push_d    = d;
        push_off  = off;
        push_sz   = sz;
        push_pend = 1;
        step();
        chk("ready_one_cycle", 32'(md_ready), 32'd0);
    endtask

    task automatic run_xfer(input logic [31:0] d, input int off, input int sz);
        bit legal;
        bit got;
        int cyc;
        begin_xfer(d, off, sz, legal);
        if (legal) begin
            wait_ready(sz, 200, got, cyc);
            chk("ready_timeout", 32'(got), 32'd1);
            if (got) finish_xfer(d, off, sz);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        md_valid = 1'b0;
        d_valid  = 1'b0;
        step();
        chk("rst_ready", 32'(md_ready), 32'd0);
        chk("rst_err", 32'(md_err), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        bit legal;
        bit got;
        int cyc;
        reset = 1'b1; md_valid = 1'b0; md_data = 32'd0; md_offset = 2'd0; md_size = 3'd0;
        out_ready = 1'b0;
        d_valid = 1'b0; d_data = 32'd0; d_offset = 2'd0; d_size = 3'd0; d_out_ready = 1'b0;
        do_reset();
        chk("rst_d3_fill", 32'(d_fill), 32'd0);

        // Basic transfer: ready after two edges, bytes BB then CC
        begin_xfer(32'hDDCCBBAA, 1, 2, legal);
        wait_ready(2, 10, got, cyc);
        chk("t1_latency", 32'(cyc), 32'd1);
        finish_xfer(32'hDDCCBBAA, 1, 2);
        chk("t1_head", 32'(out_data), 32'hBB);
        pop_budget = 1;
        step();
        chk("t1_second", 32'(out_data), 32'hCC);
        pop_budget = 1;
        step();

        // Illegal transfers: size 0 and offset+size overflow
        begin_xfer(32'h12345678, 0, 0, legal);
        begin_xfer(32'h12345678, 3, 2, legal);
        chk("t2_fill", 32'(fill_level), 32'd0);

        // Protocol violation: valid drops in WAIT, nothing pushed, no ready
        begin_xfer(32'hCAFEF00D, 0, 4, legal);
        md_valid = 1'b0;
        step();
        chk("viol_no_ready", 32'(md_ready), 32'd0);
        step();
        chk("viol_no_ready2", 32'(md_ready), 32'd0);

        // Full FIFO stalls a fifth word until four bytes drain
        pop_budget = 0;
        for (int k = 0; k < 4; k++) run_xfer(32'h01020304 * (k + 1), 0, 4);
        chk("t3_full", 32'(fill_level), 32'd16);
        begin_xfer(32'hA1B2C3D4, 0, 4, legal);
        wait_ready(4, 3, got, cyc);
        chk("t3_stall", 32'(got), 32'd0);
        pop_budget = 1;
        wait_ready(4, 3, got, cyc);
        chk("t3_stall_one_pop", 32'(got), 32'd0);
        chk("t3_fill15", 32'(fill_level), 32'd15);
        pop_budget = 3;
        wait_ready(4, 10, got, cyc);
        chk("t3_release", 32'(got), 32'd1);
        if (got) finish_xfer(32'hA1B2C3D4, 0, 4);
        chk("t3_fill16", 32'(fill_level), 32'd16);
        pop_budget = 16;
        for (int k = 0; k < 17; k++) step();

        // READY_DELAY=3 instance: ready exactly four edges after valid is seen
        d_data = 32'h000000A5; d_offset = 2'd0; d_size = 3'd1; d_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("d3_ready_edge", 32'(d_ready), 32'(k == 4));
            chk("d3_err", 32'(d_err), 32'd0);
        end
        d_valid = 1'b0;
        step();
        chk("d3_ready_drop", 32'(d_ready), 32'd0);
        chk("d3_fill", 32'(d_fill), 32'd1);
        chk("d3_byte", 32'(d_out_data), 32'hA5);

        // Wrap: 14 bytes through, then a word straddling index 15/0
        do_reset();
        pop_budget = 0;
        run_xfer(32'h0A0B0C0D, 0, 4);
        run_xfer(32'h1A1B1C1D, 0, 4);
        run_xfer(32'h2A2B2C2D, 0, 4);
        run_xfer(32'h3A3B3C3D, 2, 2);
        pop_budget = 14;
        for (int k = 0; k < 15; k++) step();
        run_xfer(32'h44332211, 0, 4);
        chk("t5_b0", 32'(out_data), 32'h11);
        pop_budget = 4;
        step(); chk("t5_b1", 32'(out_data), 32'h22);
        step(); chk("t5_b2", 32'(out_data), 32'h33);
        step(); chk("t5_b3", 32'(out_data), 32'h44);
        step(); chk("t5_empty", 32'(out_valid), 32'd0);

        // Reset while in WAIT with five bytes held
        pop_budget = 0;
        run_xfer(32'h55667788, 0, 4);
        run_xfer(32'h000000EE, 0, 1);
        chk("t6_fill5", 32'(fill_level), 32'd5);
        begin_xfer(32'h00009988, 0, 2, legal);
        do_reset();
        chk("t6_fill0", 32'(fill_level), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        run_xfer(32'h00009988, 1, 2);
        chk("t6_after", 32'(fill_level), 32'd2);
        chk("t6_head", 32'(out_data), 32'h99);

        // Random transfers with random back-pressure
        pop_budget = -1;
        for (int k = 0; k < 60; k++) begin
            run_xfer($urandom, $urandom_range(0, 3), $urandom_range(0, 4));
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
        for (int k = 0; k < 60; k++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
